// File: rtl/i2c_master.sv
// i2c_master: byte-level I2C master with START/STOP framing, ACK handling and SCL clock stretching.
module i2c_master #(
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic        rd,
    inout  wire  [11:0] dbus,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        i2c_scl_out,
    output logic        i2c_sda_out,
    output logic        busy
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;
    state_t      state_q, state_d;
    logic [1:0]  ph_q, ph_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [11:0] cmd_q, cmd_d;
    logic [7:0]  rx_q, rx_d;
    logic        nack_q, nack_d;
    logic        stall, tick, sample;
    assign busy   = state_q != S_IDLE;
    assign dbus   = rd ? {busy, nack_q, 2'b00, rx_q} : 'z;
    // a slave holding SCL low freezes the high phase until the line really rises
    assign stall  = ph_q == 2'd1 && i2c_scl_out && !scl_in;
    assign tick   = !stall && cnt_q == 8'(DIV - 1);
    assign sample = tick && ph_q == 2'd2;
    always_comb begin
        i2c_scl_out = 1'b1;
        i2c_sda_out = 1'b1;
        case (state_q)
            S_START: begin
                i2c_scl_out = ph_q != 2'd3;
                i2c_sda_out = ph_q < 2'd2;
            end
            S_BIT: begin
                i2c_scl_out = ph_q == 2'd1 || ph_q == 2'd2;
                i2c_sda_out = cmd_q[10] | cmd_q[3'd7 - bit_q];
            end
            S_ACK: begin
                i2c_scl_out = ph_q == 2'd1 || ph_q == 2'd2;
                i2c_sda_out = cmd_q[10] ? cmd_q[11] : 1'b1;
            end
            S_STOP: begin
                i2c_scl_out = ph_q != 2'd0;
                i2c_sda_out = ph_q[1];
            end
            default: ;
        endcase
    end
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        cmd_d   = cmd_q;
        rx_d    = rx_q;
        nack_d  = nack_q;
        if (state_q == S_IDLE) begin
            if (wr) begin
                cmd_d   = dbus;
                state_d = dbus[8] ? S_START : S_BIT;
            end
        end else if (!stall) begin
            cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
            if (tick) begin
                ph_d = ph_q + 2'd1;
                if (sample && state_q == S_BIT && cmd_q[10])
                    rx_d = {rx_q[6:0], sda_in};
                if (sample && state_q == S_ACK)
                    nack_d = !cmd_q[10] && sda_in;
                if (ph_q == 2'd3) begin
                    bit_d   = state_q == S_BIT ? bit_q + 3'd1 : bit_q;
                    state_d = state_q == S_START ? S_BIT :
                              state_q == S_BIT ? (bit_q == 3'd7 ? S_ACK : S_BIT) :
                              state_q == S_ACK && cmd_q[9] ? S_STOP : S_IDLE;
                end
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            cmd_q   <= '0;
            rx_q    <= '0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            cmd_q   <= cmd_d;
            rx_q    <= rx_d;
            nack_q  <= nack_d;
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: randomized scoreboard bench with a bus-level slave, bus monitor and status checker.
module tb_i2c_master;
    localparam int DIV = 4;
    localparam int STATE_CYC = 4 * DIV;
    typedef struct {
        int         cycles;
        logic [8:0] bits;
        logic       st;
        logic       sp;
    } txn_t;
    logic        clk = 0, rst = 1, wr = 0, rd = 0, tb_en = 0;
    logic [11:0] tb_drv = '0;
    wire  [11:0] dbus;
    logic        scl_out, sda_out, busy;
    logic        scl_hold = 0, slave_sda = 1;
    wire         scl_in = scl_out & ~scl_hold;
    wire         sda_in = sda_out & slave_sda;
    logic        cfg_read = 0, cfg_ack = 0, cfg_stretch = 0;
    logic [7:0]  cfg_byte = '0;
    logic [7:0]  m_rx = '0;
    logic        m_nack = 0;
    txn_t        exp_q[$];
    logic [11:0] stat_q[$];
    int          checks = 0, errors = 0;

    assign dbus = tb_en ? tb_drv : 'z;
    always #5 clk = ~clk;

    i2c_master #(.DIV(DIV)) dut (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .dbus(dbus),
        .scl_in(scl_in), .sda_in(sda_in),
        .i2c_scl_out(scl_out), .i2c_sda_out(sda_out), .busy(busy)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // monitor: bus-level slave, bus decoder and scoreboard comparisons
    int         k = 0, rises = 0, orises = 0, hold_cnt = 0, cyc = 0, idx;
    logic [8:0] bits = '0;
    logic       st = 0, sp = 0, pscl = 1, psda = 1, pout = 1, pbusy = 0, c_scl, c_sda;
    txn_t       e;
    always @(negedge clk) begin
        if (rst) begin
            pscl = 1; psda = 1; pout = 1; pbusy = 0;
            scl_hold = 0; slave_sda = 1; hold_cnt = 0;
        end else begin
            c_scl = scl_in;
            c_sda = sda_in;
            if (busy && !pbusy) begin
                k = 0; rises = 0; orises = 0; bits = '0; st = 0; sp = 0; cyc = 0;
                chk("txn_pending", exp_q.size(), 1);
            end
            if (pscl && c_scl && psda && !c_sda) st = 1;
            if (pscl && c_scl && !psda && c_sda) sp = 1;
            if (!pscl && c_scl && rises < 9) begin
                bits[8 - rises] = c_sda;
                rises++;
            end
            if (pscl && !c_scl) begin
                k++;
                idx = k - 1;
                slave_sda = (idx < 8 && cfg_read) ? cfg_byte[7 - idx] :
                            (idx == 8 && !cfg_read) ? ~cfg_ack : 1'b1;
            end
            if (!pout && scl_out) orises++;
            if (cfg_stretch && busy && pout && !scl_out && orises == 3) begin
                scl_hold = 1;
                hold_cnt = 20;
            end else if (scl_hold && scl_out) begin
                if (hold_cnt == 0) scl_hold = 0;
                else hold_cnt--;
            end
            if (busy) cyc++;
            if (!busy && pbusy && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("busy_cycles", cyc, e.cycles);
                chk("bus_bits", int'(bits), int'(e.bits));
                chk("start_seen", int'(st), int'(e.st));
                chk("stop_seen", int'(sp), int'(e.sp));
            end
            if (rd) begin
                chk("status_pending", stat_q.size(), 1);
                if (stat_q.size() > 0) chk("status", int'(dbus), int'(stat_q.pop_front()));
            end
            pscl = c_scl; psda = c_sda; pout = scl_out; pbusy = busy;
        end
    end

    task automatic issue(input logic [11:0] cmd, input logic ack, input logic [7:0] sb, input logic stretch);
        txn_t t;
        t.cycles = STATE_CYC * (9 + int'(cmd[8]) + int'(cmd[9])) + (stretch ? 20 : 0);
        t.bits   = cmd[10] ? {sb, cmd[11]} : {cmd[7:0], ~ack};
        t.st     = cmd[8];
        t.sp     = cmd[9];
        if (cmd[10]) begin
            m_rx   = sb;
            m_nack = 0;
        end else m_nack = ~ack;
        cfg_read = cmd[10]; cfg_ack = ack; cfg_byte = sb; cfg_stretch = stretch;
        exp_q.push_back(t);
        @(posedge clk); #1;
        wr = 1; tb_en = 1; tb_drv = cmd;
        @(posedge clk); #1;
        wr = 0; tb_en = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic read_status();
        stat_q.push_back({1'b0, m_nack, 2'b00, m_rx});
        @(posedge clk); #1;
        rd = 1;
        @(posedge clk); #1;
        rd = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] old, cmd;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_scl", int'(scl_out), 1);
        chk("reset_sda", int'(sda_out), 1);
        chk("reset_busy", int'(busy), 0);
        rst = 0;
        read_status();
        issue(12'h3A5, 1, 8'h00, 0); wait_idle(); read_status();
        issue(12'h1A5, 0, 8'h00, 0); wait_idle(); read_status();
        issue(12'hC00, 0, 8'h5C, 0); wait_idle(); read_status();
        issue(12'h3A5, 1, 8'h00, 1); wait_idle(); read_status();
        // write while busy is dropped; rd+wr together returns the pre-wr status
        old = {1'b1, m_nack, 2'b00, m_rx};
        issue(12'h3A5, 1, 8'h00, 0);
        repeat (20) @(posedge clk);
        #1; wr = 1; tb_en = 1; tb_drv = 12'h2FF;
        @(posedge clk);
        #1; wr = 0; tb_en = 0;
        repeat (10) @(posedge clk);
        #1; stat_q.push_back(old); rd = 1; wr = 1;
        @(posedge clk);
        #1; rd = 0; wr = 0;
        wait_idle();
        repeat (10) @(negedge clk);
        chk("ignored_wr_busy", int'(busy), 0);
        read_status();
        // reset in the middle of bit 2 (SCL low phase)
        issue(12'h3A5, 1, 8'h00, 0);
        repeat (60) @(posedge clk);
        #3; rst = 1;
        #1;
        chk("midreset_scl", int'(scl_out), 1);
        chk("midreset_sda", int'(sda_out), 1);
        chk("midreset_busy", int'(busy), 0);
        exp_q.delete();
        m_rx = '0; m_nack = 0; cfg_stretch = 0;
        @(posedge clk);
        #1; rst = 0;
        read_status();
        for (int i = 0; i < 12; i++) begin
            cmd = 12'($urandom_range(0, 4095));
            if (i == 0) cmd[8] = 1'b1;
            issue(cmd, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
            wait_idle();
            read_status();
        end
        repeat (5) @(negedge clk);
        chk("queues_drained", exp_q.size() + stat_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
